im_loader: RTL and testbench

- Byte-stream writer for the CPU instruction memory: the write-side counterpart of the IF stage's instruction fetch.
- Accepts a framed byte stream on a valid/ready port and assembles big-endian 32-bit instruction words.
- Writes each word into IM via a single-cycle write strobe, validates a trailing XOR checksum, and holds the CPU (cpu_hold) until a good image is loaded.
- Sits beside the CPU at top level; it replaces file-based IM initialisation for hardware bring-up.

---
 rtl/im_loader_pkg.sv | 23 ++
 rtl/im_loader_if.sv | 9 +
 rtl/im_word_packer.sv | 28 ++
 rtl/im_loader.sv | 97 +++++++++
 tb/tb_im_loader.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/im_loader_pkg.sv
// Shared framing constants and FSM encoding for the instruction-memory loader,
// used by the RTL, the host-side packer and the bench alike.
package im_loader_pkg;

   typedef enum logic [2:0] {
      S_LENH = 3'd0,
      S_LENL = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int CSUM_W         = 8;
   localparam int BYTES_PER_WORD = 4;

   function automatic logic [CSUM_W-1:0] csum_fold(input logic [CSUM_W-1:0] acc,
                                                   input logic [7:0]        b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream valid/ready port feeding the instruction-memory loader.
interface im_loader_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/im_word_packer.sv
// Shifts accepted bytes MSB-first into a 32-bit word and flags the byte that
// completes each word.
module im_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_done
);
   logic [1:0]  byte_cnt;
   logic [23:0] asm_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)         byte_cnt <= 2'd0;
      else if (clear)    byte_cnt <= 2'd0;
      else if (shift_en) byte_cnt <= byte_cnt + 2'd1;
   end

   // Only the three leading bytes are stored; the fourth completes the word in flight.
   always_ff @(posedge clk) begin
      if (shift_en) asm_r <= {asm_r[15:0], byte_in};
   end

   assign word_next = {asm_r, byte_in};
   assign word_done = shift_en && (byte_cnt == 2'd3);
endmodule

// File: rtl/im_loader.sv
// Framed byte-stream loader for the instruction memory; holds the CPU until a
// checksum-verified image has been written.
module im_loader
   import im_loader_pkg::*;
#(
   parameter int NMEM = 20,
   parameter int AW   = 5
) (
   input  logic          clk,
   input  logic          reset,
   im_loader_if.slave    s,
   input  logic          restart,
   output logic          im_we,
   output logic [AW-1:0] im_addr,
   output logic [31:0]   im_wdata,
   output logic          cpu_hold,
   output logic          done,
   output logic          err,
   output logic [AW:0]   words_loaded
);
   localparam logic [15:0] NMEM_W = 16'(NMEM);

   state_t            state, state_n;
   logic              accept, rearm, last_word, word_done;
   logic [15:0]       len, len_full;
   logic [AW:0]       word_cnt;
   logic [CSUM_W-1:0] csum;
   logic [31:0]       word_next;

   assign s.s_ready    = state inside {S_LENH, S_LENL, S_DATA, S_CSUM};
   assign accept       = s.s_valid && s.s_ready;
   assign rearm        = restart && (state == S_DONE || state == S_ERR);
   assign len_full     = {len[15:8], s.s_data};
   assign last_word    = (16'(word_cnt) + 16'd1) == len;
   assign words_loaded = word_cnt;

   im_word_packer u_packer (
      .clk       (clk),
      .reset     (reset),
      .clear     (rearm),
      .shift_en  (accept && state == S_DATA),
      .byte_in   (s.s_data),
      .word_next (word_next),
      .word_done (word_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_LENH;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_LENH: if (accept) state_n = S_LENL;
         S_LENL: if (accept)
                    state_n = (len_full == 16'd0 || len_full > NMEM_W) ? S_ERR : S_DATA;
         S_DATA: if (word_done && last_word) state_n = S_CSUM;
         S_CSUM: if (accept) state_n = (s.s_data == csum) ? S_DONE : S_ERR;
         S_DONE, S_ERR: if (restart) state_n = S_LENH;
         default: state_n = S_LENH;
      endcase
   end

   // Status flags follow the next state so they change together with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len      <= '0;
         word_cnt <= '0;
         csum     <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         cpu_hold <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         im_we    <= word_done;
         done     <= (state_n == S_DONE);
         err      <= (state_n == S_ERR);
         cpu_hold <= (state_n != S_DONE);
         if (rearm) begin
            len      <= '0;
            word_cnt <= '0;
            csum     <= '0;
         end
         if (accept && state == S_LENH) len[15:8] <= s.s_data;
         if (accept && state == S_LENL) len[7:0]  <= s.s_data;
         if (accept && state == S_DATA) csum      <= csum_fold(csum, s.s_data);
         if (word_done) begin
            im_addr  <= word_cnt[AW-1:0];
            im_wdata <= word_next;
            word_cnt <= word_cnt + (AW+1)'(1);
         end
      end
   end
endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: a byte-count based frame model predicts every output each
// cycle, plus hand-computed literal checks on the loaded image.
module tb_im_loader;
   import im_loader_pkg::*;

   localparam int NMEM = 20;
   localparam int AW   = 5;
   localparam int BUDGET = 2000;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          restart = 1'b0;
   logic          im_we, cpu_hold, done, err;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_wdata;
   logic [AW:0]   words_loaded;

   im_loader_if ifc ();

   im_loader #(.NMEM(NMEM), .AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .s            (ifc),
      .restart      (restart),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_hold     (cpu_hold),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [7:0]  frm[$];
   int          acc_n = 0;
   int          exp_words = 0;
   int          exp_addr = 0;
   logic [31:0] exp_data = '0;
   bit          exp_we = 1'b0;
   bit          chk_en = 1'b0;
   int          n_we = 0;
   int          last_addr = 0;
   logic [31:0] bench_mem [0:NMEM-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame model: everything derives from bytes accepted so far
   function automatic int flen();
      if (frm.size() < HDR_BYTES) return 0;
      return int'({frm[0], frm[1]});
   endfunction

   function automatic bit len_ok();
      return frm.size() >= HDR_BYTES && flen() != 0 && flen() <= NMEM;
   endfunction

   function automatic int consumed();
      if (frm.size() < HDR_BYTES) return 1 << 30;
      return len_ok() ? HDR_BYTES + 4 * flen() + 1 : HDR_BYTES;
   endfunction

   function automatic bit ended();
      return acc_n >= consumed();
   endfunction

   function automatic bit csum_good();
      logic [7:0] x = 8'h00;
      int n = flen();
      for (int i = 0; i < 4 * n; i++) x ^= frm[HDR_BYTES + i];
      return x == frm[HDR_BYTES + 4 * n];
   endfunction

   function automatic bit exp_done();
      return ended() && len_ok() && csum_good();
   endfunction

   function automatic bit exp_err();
      return ended() && !(len_ok() && csum_good());
   endfunction

   task automatic model_update(input bit hs, input bit rs);
      int idx;
      exp_we = 1'b0;
      if (hs) begin
         idx = acc_n;
         if (len_ok() && idx >= HDR_BYTES && idx < HDR_BYTES + 4 * flen()
             && (idx - HDR_BYTES) % 4 == 3) begin
            exp_we   = 1'b1;
            exp_addr = (idx - HDR_BYTES) / 4;
            exp_data = {frm[idx-3], frm[idx-2], frm[idx-1], frm[idx]};
            exp_words++;
         end
         acc_n++;
      end else if (rs && ended()) begin
         acc_n     = 0;
         exp_words = 0;
      end
   endtask

   task automatic model_clear();
      acc_n = 0; exp_words = 0; exp_we = 1'b0;
   endtask

   // ---------------- compare process
   always @(negedge clk) begin
      if (chk_en) begin
         chk("s_ready", 32'(ifc.s_ready), 32'(!ended()));
         chk("im_we", 32'(im_we), 32'(exp_we));
         if (exp_we) begin
            chk("im_addr", 32'(im_addr), 32'(exp_addr));
            chk("im_wdata", im_wdata, exp_data);
         end
         chk("done", 32'(done), 32'(exp_done()));
         chk("err", 32'(err), 32'(exp_err()));
         chk("cpu_hold", 32'(cpu_hold), 32'(!exp_done()));
         chk("words_loaded", 32'(words_loaded), 32'(exp_words));
         if (im_we) begin
            bench_mem[im_addr] = im_wdata;
            last_addr = int'(im_addr);
            n_we++;
         end
      end
   end

   // ---------------- stimulus
   task automatic step(input bit v, input logic [7:0] d, input bit rs);
      bit hs;
      ifc.s_valid = v;
      ifc.s_data  = d;
      restart     = rs;
      hs = v && !ended();
      @(posedge clk);
      #1;
      model_update(hs, rs);
      @(negedge clk);
   endtask

   task automatic build(input logic [15:0] lenf, input int nw,
                        input logic [31:0] w0, input logic [31:0] w1, input bit good);
      logic [7:0]  x = 8'h00;
      logic [31:0] w;
      frm.delete();
      frm.push_back(lenf[15:8]);
      frm.push_back(lenf[7:0]);
      for (int i = 0; i < nw; i++) begin
         w = (i == 0) ? w0 : (i == 1) ? w1 : ((32'h01000193 * i) ^ 32'h5A5AA5A5);
         for (int b = 3; b >= 0; b--) begin
            frm.push_back(w[8*b +: 8]);
            x ^= w[8*b +: 8];
         end
      end
      if (nw > 0) frm.push_back(good ? x : (x ^ 8'h88));
   endtask

   task automatic run_frame(input bit stall, input int rs_at, input int stop_at);
      int cyc = 0;
      bit v, rs;
      bit rs_fired = 1'b0;
      n_we = 0;
      while (!ended() && acc_n < stop_at && cyc < BUDGET) begin
         v  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         rs = (acc_n == rs_at) && !rs_fired;
         if (rs) rs_fired = 1'b1;
         step(v, frm[acc_n], rs);
         cyc++;
      end
      chk("frame_budget", 32'(cyc < BUDGET), 32'd1);
      if (ended()) repeat (3) step(1'b1, 8'hEE, 1'b0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_s_ready"}, 32'(ifc.s_ready), 32'd1);
      chk({tag, "_im_we"}, 32'(im_we), 32'd0);
      chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
      chk({tag, "_im_wdata"}, im_wdata, 32'd0);
      chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_words"}, 32'(words_loaded), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NMEM; i++) bench_mem[i] = '0;
      ifc.s_valid = 1'b0;
      ifc.s_data  = 8'h00;
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check_reset_vals("rst");

      // Two-word load; payload XOR of 12 34 56 78 9A BC DE F0 is 0x00.
      build(16'd2, 2, 32'h12345678, 32'h9ABCDEF0, 1'b1);
      chk("csum_byte_a", 32'(frm[10]), 32'h00);
      run_frame(1'b0, -1, 1 << 30);
      chk("a_mem0", bench_mem[0], 32'h12345678);
      chk("a_mem1", bench_mem[1], 32'h9ABCDEF0);
      chk("a_nwe", 32'(n_we), 32'd2);
      chk("a_done", 32'(done), 32'd1);
      chk("a_hold", 32'(cpu_hold), 32'd0);
      chk("a_words", 32'(words_loaded), 32'd2);

      // Bad checksum (0x88): both words still written.
      step(1'b0, 8'h00, 1'b1);
      build(16'd2, 2, 32'h12345678, 32'h9ABCDEF0, 1'b0);
      run_frame(1'b0, -1, 1 << 30);
      chk("b_nwe", 32'(n_we), 32'd2);
      chk("b_err", 32'(err), 32'd1);
      chk("b_hold", 32'(cpu_hold), 32'd1);
      chk("b_ready", 32'(ifc.s_ready), 32'd0);

      // Length 0 and length NMEM+1.
      step(1'b0, 8'h00, 1'b1);
      build(16'd0, 0, '0, '0, 1'b1);
      run_frame(1'b0, -1, 1 << 30);
      chk("len0_nwe", 32'(n_we), 32'd0);
      chk("len0_err", 32'(err), 32'd1);
      step(1'b0, 8'h00, 1'b1);
      build(16'h0015, 0, '0, '0, 1'b1);
      run_frame(1'b0, -1, 1 << 30);
      chk("len21_err", 32'(err), 32'd1);

      // Full-depth image.
      step(1'b0, 8'h00, 1'b1);
      build(16'h0014, 20, 32'h00C0FFEE, 32'h11223344, 1'b1);
      run_frame(1'b0, -1, 1 << 30);
      chk("len20_done", 32'(done), 32'd1);
      chk("len20_last_addr", 32'(last_addr), 32'd19);
      chk("len20_nwe", 32'(n_we), 32'd20);
      chk("len20_words", 32'(words_loaded), 32'd20);

      // Stalled source.
      step(1'b0, 8'h00, 1'b1);
      build(16'd2, 2, 32'h12345678, 32'h9ABCDEF0, 1'b1);
      run_frame(1'b1, -1, 1 << 30);
      chk("stall_mem0", bench_mem[0], 32'h12345678);
      chk("stall_mem1", bench_mem[1], 32'h9ABCDEF0);
      chk("stall_nwe", 32'(n_we), 32'd2);

      // Reset after 6 payload bytes, then a fresh frame.
      step(1'b0, 8'h00, 1'b1);
      run_frame(1'b0, -1, HDR_BYTES + 6);
      #2 reset = 1'b1;
      ifc.s_valid = 1'b0;
      frm.delete();
      model_clear();
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");
      chk("midrst_nwe", 32'(n_we), 32'd1);
      build(16'd2, 2, 32'hCAFEBABE, 32'h0BADF00D, 1'b1);
      run_frame(1'b0, -1, 1 << 30);
      chk("c_mem0", bench_mem[0], 32'hCAFEBABE);
      chk("c_done", 32'(done), 32'd1);

      // Restart after done; a mid-frame restart pulse must be ignored.
      step(1'b0, 8'h00, 1'b1);
      chk("rs_hold", 32'(cpu_hold), 32'd1);
      chk("rs_done", 32'(done), 32'd0);
      chk("rs_ready", 32'(ifc.s_ready), 32'd1);
      build(16'd2, 2, 32'hDEADBEEF, 32'h01020304, 1'b1);
      run_frame(1'b0, 5, 1 << 30);
      chk("d_mem0", bench_mem[0], 32'hDEADBEEF);
      chk("d_mem1", bench_mem[1], 32'h01020304);
      chk("d_done", 32'(done), 32'd1);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
